// File: rtl/seg7_result_decoder.sv
// Decodes a two-digit active-low 7-segment display word into {err, carry, sum}
// and buffers the results in a small FIFO with valid/ready handshakes on both sides.
module seg7_result_decoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [13:0]              in_seg,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_sum,
  output logic                     out_carry,
  output logic                     out_err,
  output logic [7:0]               err_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          run;
  logic [3:0]    dec_sum;
  logic          dec_carry;
  logic          dec_err;
  logic          push;
  logic          pop;

  always_comb begin
    dec_sum   = 4'h0;
    dec_carry = 1'b0;
    dec_err   = 1'b0;
    case (in_seg[6:0])
      7'h40: dec_sum = 4'h0;
      7'h79: dec_sum = 4'h1;
      7'h24: dec_sum = 4'h2;
      7'h30: dec_sum = 4'h3;
      7'h19: dec_sum = 4'h4;
      7'h12: dec_sum = 4'h5;
      7'h02: dec_sum = 4'h6;
      7'h78: dec_sum = 4'h7;
      7'h00: dec_sum = 4'h8;
      7'h10: dec_sum = 4'h9;
      7'h08: dec_sum = 4'hA;
      7'h03: dec_sum = 4'hB;
      7'h46: dec_sum = 4'hC;
      7'h21: dec_sum = 4'hD;
      7'h06: dec_sum = 4'hE;
      7'h0E: dec_sum = 4'hF;
      default: begin
        dec_sum = 4'h0;
        dec_err = 1'b1;
      end
    endcase
    case (in_seg[13:7])
      7'h40: dec_carry = 1'b0;
      7'h79: dec_carry = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  // run holds in_ready low through reset and for the edge that follows release
  assign in_ready  = run && (level != FULL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign {out_err, out_carry, out_sum} = out_valid ? mem[rd_ptr] : 6'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      err_cnt <= 8'h00;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (push && dec_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'h01;
    end
  end

  // Storage needs no reset: entries are only visible while level covers them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dec_err, dec_carry, dec_sum};
  end

endmodule

// File: tb/tb_seg7_result_decoder.sv
// Scoreboard bench for seg7_result_decoder: stimulus queues hand-computed
// {err, carry, sum} entries, a monitor pops and compares on every output handshake.
module tb_seg7_result_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [13:0] in_seg = 14'h0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_sum;
  logic        out_carry;
  logic        out_err;
  logic [7:0]  err_cnt;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  logic [5:0] sb[$];

  localparam logic [6:0] C0 = 7'h40;
  localparam logic [6:0] C1 = 7'h79;
  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_result_decoder #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_seg(in_seg),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_err(out_err),
    .err_cnt(err_cnt), .level(level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one word for one edge; exp_accept says whether the FIFO should take it
  task automatic applyStimulus(input logic [13:0] seg, input logic [5:0] exp, input bit exp_accept);
    in_valid = 1'b1;
    in_seg   = seg;
    @(negedge clk);
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_accept});
    if (exp_accept) begin
      sb.push_back(exp);
      if (exp[5] && exp_err < 255) exp_err++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: got entry %0h expected none", {out_err, out_carry, out_sum});
      end else begin
        checkOutput("scoreboard", {26'b0, out_err, out_carry, out_sum}, {26'b0, sb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 0);
    checkOutput("rst_level", {29'b0, level}, 0);
    checkOutput("rst_err_cnt", {24'b0, err_cnt}, 0);
    checkOutput("rst_fields", {26'b0, out_err, out_carry, out_sum}, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1 checkOutput("pre_edge_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk);
    #1 checkOutput("post_edge_in_ready", {31'b0, in_ready}, 1);

    // Single word {79,00}: carry 1, sum 8
    out_ready = 1'b1;
    applyStimulus({C1, 7'h00}, 6'h18, 1'b1);
    checkOutput("single_valid", {31'b0, out_valid}, 1);
    idle(1);
    checkOutput("single_level", {29'b0, level}, 0);
    checkOutput("empty_fields", {26'b0, out_err, out_carry, out_sum}, 0);

    // Fill to full with backpressure; the illegal 5th word must be dropped
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus({C0, pat[i]}, {2'b00, 4'(i)}, 1'b1);
    checkOutput("full_level", {29'b0, level}, 4);
    checkOutput("full_in_ready", {31'b0, in_ready}, 0);
    applyStimulus({C0, 7'h7F}, 6'h20, 1'b0);
    checkOutput("full_level_hold", {29'b0, level}, 4);
    checkOutput("full_err_cnt", {24'b0, err_cnt}, 32'(exp_err));
    idle(2);
    checkOutput("stall_oldest", {26'b0, out_err, out_carry, out_sum}, 0);
    out_ready = 1'b1;
    idle(4);
    out_ready = 1'b0;
    checkOutput("drain_level", {29'b0, level}, 0);
    checkOutput("drain_sb", 32'(sb.size()), 0);

    // Illegal sum, illegal carry, then a few legal words
    out_ready = 1'b1;
    applyStimulus({C0, 7'h7F}, 6'h20, 1'b1);
    checkOutput("err_cnt_1", {24'b0, err_cnt}, 1);
    applyStimulus({7'h24, pat[1]}, 6'h21, 1'b1);
    checkOutput("err_cnt_2", {24'b0, err_cnt}, 2);
    applyStimulus({C1, pat[15]}, 6'h1F, 1'b1);
    applyStimulus({C0, pat[12]}, 6'h0C, 1'b1);
    applyStimulus({C1, pat[13]}, 6'h1D, 1'b1);
    idle(2);
    checkOutput("legal_level", {29'b0, level}, 0);
    checkOutput("legal_err_cnt", {24'b0, err_cnt}, 2);

    // Steady push/pop at level 2 across pointer wrap
    out_ready = 1'b0;
    applyStimulus({C0, pat[10]}, 6'h0A, 1'b1);
    applyStimulus({C1, pat[11]}, 6'h1B, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus({(i % 2 == 1) ? C1 : C0, pat[(i + 2) % 16]},
                    {1'b0, 1'(i % 2), 4'(i + 2)}, 1'b1);
      checkOutput("steady_level", {29'b0, level}, 2);
    end
    idle(3);
    checkOutput("steady_drain", {29'b0, level}, 0);

    // err_cnt saturation under continuous drain
    repeat (300) applyStimulus({C0, 7'h7F}, 6'h20, 1'b1);
    idle(3);
    checkOutput("sat_err_cnt", {24'b0, err_cnt}, 255);

    // Asynchronous reset with three entries buffered
    out_ready = 1'b0;
    applyStimulus({C0, pat[3]}, 6'h03, 1'b1);
    applyStimulus({C0, pat[4]}, 6'h04, 1'b1);
    applyStimulus({C0, pat[5]}, 6'h05, 1'b1);
    checkOutput("pre_rst_level", {29'b0, level}, 3);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("async_out_valid", {31'b0, out_valid}, 0);
    checkOutput("async_level", {29'b0, level}, 0);
    checkOutput("async_in_ready", {31'b0, in_ready}, 0);
    checkOutput("async_err_cnt", {24'b0, err_cnt}, 0);
    checkOutput("async_fields", {26'b0, out_err, out_carry, out_sum}, 0);
    sb.delete();
    exp_err = 0;
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("rerun_in_ready", {31'b0, in_ready}, 1);
    out_ready = 1'b1;
    applyStimulus({C1, pat[6]}, 6'h16, 1'b1);
    idle(2);
    checkOutput("rerun_level", {29'b0, level}, 0);

    checkOutput("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_result_decoder.md
SEG7_RESULT_DECODER -- requirements
Module: seg7_result_decoder

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entry count; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  producer asserts when in_seg holds a display word.
REQ-005 Port: in_seg  input  14  display word; [6:0] = sum digit, [13:7] = carry digit; each digit active-low, bit order gfedcba (bit0 = a).
REQ-006 Port: in_ready  output  1  block can accept a word this cycle.
REQ-007 Port: out_valid  output  1  out_sum, out_carry and out_err hold a buffered entry.
REQ-008 Port: out_ready  input  1  consumer accepts the entry this cycle.
REQ-009 Port: out_sum  output  4  decoded sum digit.
REQ-010 Port: out_carry  output  1  decoded carry digit.
REQ-011 Port: out_err  output  1  entry contained at least one illegal pattern.
REQ-012 Port: err_cnt  output  8  saturating count of accepted words with out_err set.
REQ-013 Port: level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Digit decode table (hex pattern -> value) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
REQ-015 A sum digit not in the table SHALL decode to value 0 with the error flag set.
REQ-016 The carry digit SHALL be legal only as 40 (carry 0) or 79 (carry 1); any other pattern SHALL give carry 0 with the error flag set.
REQ-017 Decoding SHALL be combinational on in_seg; the decoded {err, carry, sum} SHALL be written into the FIFO on an accept edge.
REQ-018 An accept SHALL occur when in_valid and in_ready are both high at a rising edge.
REQ-019 in_ready SHALL equal (level < DEPTH); it SHALL not depend on out_ready, so there is no pass-through when full.
REQ-020 A pop SHALL occur when out_valid and out_ready are both high at a rising edge.
REQ-021 out_valid SHALL equal (level != 0); output fields SHALL show the oldest entry and SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 Latency: a word accepted into an empty FIFO at edge N SHALL appear with out_valid=1 after edge N, with no combinational in-to-out path.
REQ-023 Simultaneous accept and pop SHALL leave level unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 in_valid while full SHALL be ignored, with no overwrite and no change to err_cnt.
REQ-026 out_ready while empty SHALL be ignored, with no pointer or level change.
REQ-027 err_cnt SHALL increment by 1 on each accept whose decoded error flag is set, and SHALL saturate at 255.
REQ-028 While out_valid=0, out_sum, out_carry and out_err SHALL read 0.

Reset
REQ-029 When reset_n=0, pointers, level and err_cnt SHALL clear to 0 immediately, asynchronously to clk.
REQ-030 During reset, out_valid=0, in_ready=0, and out_sum/out_carry/out_err=0.
REQ-031 in_ready SHALL rise on the first rising edge after reset_n deasserts.
REQ-032 Reset mid-operation SHALL discard all buffered entries; no stale entry SHALL appear after reset.

Verification
REQ-033 Single word: push 14'h3C80 ({79,00}) into empty FIFO, out_ready=1 -> next cycle out_valid=1, out_carry=1, out_sum=8, out_err=0, then level=0.
REQ-034 Fill/backpressure: push 5 words with out_ready=0 -> in_ready=0 after the 4th accept; 5th word not stored; level=4; drain order matches push order.
REQ-035 Illegal patterns: push sum 7F, carry 40 -> out_sum=0, out_err=1, err_cnt=1; push carry 24 with legal sum -> out_carry=0, out_err=1, err_cnt=2.
REQ-036 Simultaneous push/pop at level 2 for 10 cycles -> level stays 2; outputs follow FIFO order across pointer wrap.
REQ-037 Saturation: 300 illegal words drained continuously -> err_cnt=255.
REQ-038 Reset mid-stream: assert reset_n=0 at level 3 between edges -> out_valid=0 and level=0 immediately; after release, first pushed word is the first output.
